// File: rtl/sysid_checker_pkg.sv
// sysid_checker shared definitions
// state encoding, Avalon word map, default build constants
package sysid_pkg;

  localparam int DATA_W = 32;

  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;

  localparam logic [DATA_W-1:0] DEF_EXPECTED_ID = 32'd0;
  localparam logic [DATA_W-1:0] DEF_EXPECTED_TS = 32'd1419253882;
  localparam int unsigned       DEF_TIMEOUT     = 255;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RD_ID,
    S_RD_TS,
    S_REPORT
  } state_e;

endpackage

// File: rtl/sysid_checker_if.sv
// sysid_checker Avalon-MM control bus
// master drives address/read, slave answers
interface sysid_checker_if;
  import sysid_pkg::*;

  logic              address;
  logic              read;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;

  modport master (
    output address,
    output read,
    input  waitrequest,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    output waitrequest,
    output readdata
  );

endinterface

// File: rtl/sysid_checker_stall_timer.sv
// sysid_checker stall timer
// counts stalled read cycles, flags the last allowed one
module stall_timer #(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam logic [15:0] LAST = 16'(LIMIT - 1);

  logic [15:0] cnt_q, cnt_d;

  // clear wins over count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)
      cnt_d = '0;
    else if (en_i)
      cnt_d = cnt_q + 16'd1;
  end

  // counter register
  always_ff @(posedge clk_i) begin
    if (rst_i)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // this stalled cycle is the LIMIT-th one
  assign tc_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/sysid_checker.sv
// sysid_checker top
// reads ID and timestamp words, reports build match
module sysid_checker
  import sysid_pkg::*;
#(
  parameter logic [31:0] EXPECTED_ID        = DEF_EXPECTED_ID,
  parameter logic [31:0] EXPECTED_TIMESTAMP = DEF_EXPECTED_TS,
  parameter int unsigned TIMEOUT_CYCLES     = DEF_TIMEOUT
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  sysid_checker_if.master     av,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic                err_id,
  output logic                err_ts,
  output logic                err_timeout,
  output logic [DATA_W-1:0]   id_value,
  output logic [DATA_W-1:0]   ts_value
);

  state_e            state_q, state_d;
  logic              pass_q, pass_d;
  logic              eid_q, eid_d;
  logic              ets_q, ets_d;
  logic              eto_q, eto_d;
  logic [DATA_W-1:0] id_q, id_d;
  logic [DATA_W-1:0] ts_q, ts_d;
  logic              rd_c, addr_c, done_c;
  logic              tmr_clr, tmr_en, tmr_tc;

  assign tmr_en  = rd_c && av.waitrequest;
  assign tmr_clr = (state_d != state_q);

  stall_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (tmr_clr),
    .en_i  (tmr_en),
    .tc_o  (tmr_tc)
  );

  // next state, bus strobes and result capture
  always_comb begin
    state_d = state_q;
    eid_d   = eid_q;
    ets_d   = ets_q;
    eto_d   = eto_q;
    id_d    = id_q;
    ts_d    = ts_q;
    pass_d  = pass_q;
    rd_c    = 1'b0;
    addr_c  = SYSID_ADDR_ID;
    done_c  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RD_ID;
          eid_d   = 1'b0;
          ets_d   = 1'b0;
          eto_d   = 1'b0;
          id_d    = '0;
          ts_d    = '0;
          pass_d  = 1'b0;
        end
      end
      S_RD_ID: begin
        rd_c   = 1'b1;
        addr_c = SYSID_ADDR_ID;
        if (!av.waitrequest) begin
          id_d    = av.readdata;
          eid_d   = (av.readdata != EXPECTED_ID);
          state_d = S_RD_TS;
        end else if (tmr_tc) begin
          eto_d   = 1'b1;
          state_d = S_REPORT;
        end
      end
      S_RD_TS: begin
        rd_c   = 1'b1;
        addr_c = SYSID_ADDR_TS;
        if (!av.waitrequest) begin
          ts_d    = av.readdata;
          ets_d   = (av.readdata != EXPECTED_TIMESTAMP);
          state_d = S_REPORT;
        end else if (tmr_tc) begin
          eto_d   = 1'b1;
          state_d = S_REPORT;
        end
      end
      S_REPORT: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // verdict lands with done, so settle it on entry to REPORT
    if (state_d == S_REPORT && state_q != S_REPORT)
      pass_d = !(eid_d || ets_d || eto_d);
  end

  // state and result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      pass_q  <= 1'b0;
      eid_q   <= 1'b0;
      ets_q   <= 1'b0;
      eto_q   <= 1'b0;
      id_q    <= '0;
      ts_q    <= '0;
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      eid_q   <= eid_d;
      ets_q   <= ets_d;
      eto_q   <= eto_d;
      id_q    <= id_d;
      ts_q    <= ts_d;
    end
  end

  assign av.read     = rd_c;
  assign av.address  = addr_c;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_c;
  assign pass        = pass_q;
  assign err_id      = eid_q;
  assign err_ts      = ets_q;
  assign err_timeout = eto_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;

endmodule
